// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - shared types and helpers for the parity serial receiver/transmitter pair
package parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Parity bit a sender must attach so the whole frame has the requested parity.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_serial_receiver_bit_sync.sv
// rtl/parity_serial_receiver_bit_sync.sv - two-flop synchroniser with configurable reset level
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/parity_serial_receiver.sv
// rtl/parity_serial_receiver.sv - oversampling 8-bit serial receiver with parity and framing checks
module parity_serial_receiver
  import parity_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       RxIn,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 sample;

  bit_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (Clk),
    .reset(Reset),
    .d    (RxIn),
    .q    (rx_s)
  );

  assign sample = (cnt_q == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      // Recheck at mid start bit so short glitches are dropped without output.
      START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = FULL_M1;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = FULL_M1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARITY: begin
        if (sample) begin
          par_d   = rx_s;
          cnt_d   = FULL_M1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (sample) begin
          data_d  = shift_q;
          perr_d  = (par_q != expected_parity(shift_q, PARITY_ODD));
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // A low stop bit means break or stuck line; wait for idle before hunting again.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    Data      = data_q;
    Valid     = valid_q;
    ParityErr = perr_q;
    FrameErr  = ferr_q;
    Busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_parity_serial_receiver.sv
// tb/tb_parity_serial_receiver.sv - randomized self-checking bench for parity_serial_receiver
module tb_parity_serial_receiver;

  localparam int C       = 4;
  localparam int LAT_NOM = 2 + C / 2 + 10 * C + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx_e  = 1'b1;
  logic       rx_o  = 1'b1;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  rec_t q_e[$];
  rec_t q_o[$];

  parity_serial_receiver #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) u_even (
    .Clk(clk), .Reset(reset), .RxIn(rx_e), .Data(data_e), .Valid(valid_e),
    .ParityErr(perr_e), .FrameErr(ferr_e), .Busy(busy_e)
  );

  parity_serial_receiver #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) u_odd (
    .Clk(clk), .Reset(reset), .RxIn(rx_o), .Data(data_o), .Valid(valid_o),
    .ParityErr(perr_o), .FrameErr(ferr_o), .Busy(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_e === 1'b1) q_e.push_back('{data: data_e, perr: perr_e, ferr: ferr_e, cyc: cyc});
    if (valid_o === 1'b1) q_o.push_back('{data: data_o, perr: perr_o, ferr: ferr_o, cyc: cyc});
  end

  function automatic int ones_of(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return n;
  endfunction

  // A frame is good when the count of ones over data plus parity matches the requested parity.
  function automatic logic model_perr(input logic [7:0] b, input logic p, input bit odd);
    return ((ones_of(b) + int'(p)) % 2) != (odd ? 1 : 0);
  endfunction

  function automatic logic good_p(input logic [7:0] b, input bit odd);
    return logic'(((ones_of(b) % 2) + (odd ? 1 : 0)) % 2);
  endfunction

  task automatic to_drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_e = v;
    else rx_o = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic p, input logic stop);
    logic [10:0] f;
    f = {stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      set_line(which, f[i]);
      repeat (C) to_drive_point();
    end
  endtask

  task automatic wait_q(input int which, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * C; i++) begin
      if ((which == 0 && q_e.size() >= n) || (which == 1 && q_o.size() >= n)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (data_e !== 8'h00) begin n_fail++; $display("FAIL reset_data_e: got %0h expected 00", data_e); end
    n_checks++; if (valid_e !== 1'b0 || perr_e !== 1'b0 || ferr_e !== 1'b0) begin n_fail++; $display("FAIL reset_flags_e: got v%b p%b f%b expected 0", valid_e, perr_e, ferr_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL reset_busy_e: got %b expected 0", busy_e); end
    n_checks++; if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_odd: got d%0h v%b b%b expected 0", data_o, valid_o, busy_o); end
  endtask

  task automatic test_good_frame();
    bit ok;
    int t0;
    q_e.delete();
    to_drive_point();
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    wait_q(0, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL good_valid: got no Valid expected one"); end
    else begin
      n_checks++; if (q_e[0].data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %0h expected a5", q_e[0].data); end
      n_checks++; if (q_e[0].perr !== model_perr(8'hA5, 1'b0, 1'b0) || q_e[0].ferr !== 1'b0) begin n_fail++; $display("FAIL good_flags: got p%b f%b expected p0 f0", q_e[0].perr, q_e[0].ferr); end
      n_checks++; if (q_e[0].cyc - t0 < LAT_NOM - 1 || q_e[0].cyc - t0 > LAT_NOM + 2) begin n_fail++; $display("FAIL good_latency: got %0d expected about %0d", q_e[0].cyc - t0, LAT_NOM); end
    end
    @(negedge clk);
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b expected 0", busy_e); end
    n_checks++; if (q_e.size() != 1) begin n_fail++; $display("FAIL good_count: got %0d expected 1", q_e.size()); end
  endtask

  task automatic test_parity_error();
    bit ok;
    q_e.delete();
    to_drive_point();
    send_frame(0, 8'h01, 1'b0, 1'b1);
    wait_q(0, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL perr_valid: got no Valid expected one"); end
    else begin
      n_checks++; if (q_e[0].data !== 8'h01) begin n_fail++; $display("FAIL perr_data: got %0h expected 01", q_e[0].data); end
      n_checks++; if (q_e[0].perr !== 1'b1 || q_e[0].ferr !== 1'b0) begin n_fail++; $display("FAIL perr_flags: got p%b f%b expected p1 f0", q_e[0].perr, q_e[0].ferr); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    q_o.delete();
    to_drive_point();
    send_frame(1, 8'h00, 1'b1, 1'b1);
    send_frame(1, 8'hFF, 1'b1, 1'b1);
    wait_q(1, 2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d frames expected 2", q_o.size()); end
    else begin
      n_checks++; if (q_o[0].data !== 8'h00 || q_o[0].perr !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got d%0h p%b expected d00 p0", q_o[0].data, q_o[0].perr); end
      n_checks++; if (q_o[1].data !== 8'hFF || q_o[1].perr !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got d%0h p%b expected dff p0", q_o[1].data, q_o[1].perr); end
    end
  endtask

  task automatic test_frame_error();
    bit ok;
    q_e.delete();
    to_drive_point();
    send_frame(0, 8'h3C, good_p(8'h3C, 1'b0), 1'b0);
    repeat (19 * C) to_drive_point();
    @(negedge clk);
    wait_q(0, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ferr_valid: got no Valid expected one"); end
    else begin
      n_checks++; if (q_e[0].data !== 8'h3C || q_e[0].ferr !== 1'b1 || q_e[0].perr !== 1'b0) begin n_fail++; $display("FAIL ferr_rec: got d%0h f%b p%b expected d3c f1 p0", q_e[0].data, q_e[0].ferr, q_e[0].perr); end
    end
    n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low_line: got %b expected 1", busy_e); end
    to_drive_point();
    rx_e = 1'b1;
    repeat (C) to_drive_point();
    @(negedge clk);
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_released: got %b expected 0", busy_e); end
    n_checks++; if (q_e.size() != 1) begin n_fail++; $display("FAIL ferr_spurious: got %0d frames expected 1", q_e.size()); end
  endtask

  task automatic test_glitch();
    q_e.delete();
    to_drive_point();
    rx_e = 1'b0;
    to_drive_point();
    rx_e = 1'b1;
    repeat (C / 2 + 2) to_drive_point();
    @(negedge clk);
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy_e); end
    repeat (12 * C) @(negedge clk);
    n_checks++; if (q_e.size() != 0) begin n_fail++; $display("FAIL glitch_valid: got %0d frames expected 0", q_e.size()); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [10:0] f;
    q_e.delete();
    q_o.delete();
    f = {1'b1, 1'b0, 8'h5A, 1'b0};
    to_drive_point();
    for (int i = 0; i < 5; i++) begin
      rx_e = f[i];
      repeat (C) to_drive_point();
    end
    rx_e = f[5];
    repeat (C / 2) to_drive_point();
    reset = 1'b1;
    to_drive_point();
    reset = 1'b0;
    rx_e = 1'b1;
    @(negedge clk);
    n_checks++; if (data_e !== 8'h00 || valid_e !== 1'b0 || perr_e !== 1'b0 || ferr_e !== 1'b0 || busy_e !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got d%0h v%b p%b f%b b%b expected all 0", data_e, valid_e, perr_e, ferr_e, busy_e); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL midreset_odd_data: got %0h expected 00", data_o); end
    repeat (8 * C) @(negedge clk);
    n_checks++; if (q_e.size() != 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d frames expected 0", q_e.size()); end
    to_drive_point();
    send_frame(0, 8'h5A, good_p(8'h5A, 1'b0), 1'b1);
    wait_q(0, 1, ok);
    n_checks++;
    if (!ok || q_e[0].data !== 8'h5A || q_e[0].perr !== 1'b0 || q_e[0].ferr !== 1'b0) begin n_fail++; $display("FAIL midreset_next_frame: got %0d frames expected one 5a with no errors", q_e.size()); end
  endtask

  task automatic test_random();
    rec_t exp_e[$];
    rec_t exp_o[$];
    bit ok_e, ok_o;
    q_e.delete();
    q_o.delete();
    to_drive_point();
    for (int n = 0; n < 16; n++) begin
      int         which;
      logic [7:0] b;
      logic       p;
      which = int'($urandom_range(0, 1));
      b     = 8'($urandom_range(0, 255));
      p     = 1'($urandom_range(0, 1));
      if (which == 0) exp_e.push_back('{data: b, perr: model_perr(b, p, 1'b0), ferr: 1'b0, cyc: 0});
      else exp_o.push_back('{data: b, perr: model_perr(b, p, 1'b1), ferr: 1'b0, cyc: 0});
      send_frame(which, b, p, 1'b1);
      repeat ($urandom_range(0, 3)) to_drive_point();
    end
    wait_q(0, exp_e.size(), ok_e);
    wait_q(1, exp_o.size(), ok_o);
    repeat (2 * C) @(negedge clk);
    n_checks++; if (q_e.size() != exp_e.size() || q_o.size() != exp_o.size()) begin n_fail++; $display("FAIL rand_count: got %0d/%0d frames expected %0d/%0d", q_e.size(), q_o.size(), exp_e.size(), exp_o.size()); end
    for (int i = 0; i < exp_e.size() && i < q_e.size(); i++) begin
      n_checks++;
      if (q_e[i].data !== exp_e[i].data || q_e[i].perr !== exp_e[i].perr || q_e[i].ferr !== 1'b0) begin n_fail++; $display("FAIL rand_even_%0d: got d%0h p%b f%b expected d%0h p%b f0", i, q_e[i].data, q_e[i].perr, q_e[i].ferr, exp_e[i].data, exp_e[i].perr); end
    end
    for (int i = 0; i < exp_o.size() && i < q_o.size(); i++) begin
      n_checks++;
      if (q_o[i].data !== exp_o[i].data || q_o[i].perr !== exp_o[i].perr || q_o[i].ferr !== 1'b0) begin n_fail++; $display("FAIL rand_odd_%0d: got d%0h p%b f%b expected d%0h p%b f0", i, q_o[i].data, q_o[i].perr, q_o[i].ferr, exp_o[i].data, exp_o[i].perr); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_e  = 1'b1;
    rx_o  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
